// File: rtl/ring_seq_if.sv
// Signal bundle between a ring counter's sampled output and its sequence checker.
// The master drives the sample and resync; the checker (slave) reports status.
interface ring_seq_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int POS_W     = $clog2(WIDTH)
);
  logic                 resync;
  logic [WIDTH-1:0]     q_in;
  logic                 locked;
  logic [POS_W-1:0]     pos;
  logic                 wrap;
  logic                 err;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output resync, q_in,
    input  locked, pos, wrap, err, err_sticky, err_count
  );

  modport slave (
    input  resync, q_in,
    output locked, pos, wrap, err, err_sticky, err_count
  );
endinterface

// File: rtl/ring_sequence_checker.sv
// Monitors a one-hot rotate-left ring counter, tracking expected rotation and
// reporting position, wrap events and sequence errors with a saturating count.
//
// state  | meaning
// UNSYNC | no reference yet; waiting for a one-hot sample
// TRACK  | locked; each sample must equal rot(previous accepted sample)
// ERR    | mismatch seen; the next one-hot sample re-locks
module ring_sequence_checker #(
  parameter int WIDTH     = 4,
  parameter int POS_W     = $clog2(WIDTH),
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ring_seq_if.slave    bus
);
  typedef enum logic [1:0] {UNSYNC, TRACK, ERR} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 wrap_q, wrap_d;
  logic                 err_q, err_d;
  logic                 sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic                 q_one_hot;
  logic [POS_W-1:0]     q_index;
  logic [WIDTH-1:0]     q_rot;

  function automatic logic is_one_hot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [POS_W-1:0] bit_index(input logic [WIDTH-1:0] x);
    logic [POS_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) idx = POS_W'(i);
    end
    return idx;
  endfunction

  assign q_one_hot = is_one_hot(bus.q_in);
  assign q_index   = bit_index(bus.q_in);
  assign q_rot     = {bus.q_in[WIDTH-2:0], bus.q_in[WIDTH-1]};

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    pos_d      = pos_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    sticky_d   = sticky_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      UNSYNC: begin
        if (q_one_hot) begin
          expected_d = q_rot;
          pos_d      = q_index;
          state_d    = TRACK;
        end
      end
      TRACK: begin
        if (bus.resync) begin
          // A resync re-references the tracker and suppresses both compare and wrap.
          if (q_one_hot) begin
            expected_d = q_rot;
            pos_d      = q_index;
          end else begin
            state_d = UNSYNC;
          end
        end else if (bus.q_in == expected_q) begin
          expected_d = q_rot;
          pos_d      = q_index;
          wrap_d     = bus.q_in[0] && (pos_q == POS_W'(WIDTH - 1));
        end else begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
          state_d  = ERR;
        end
      end
      ERR: begin
        if (q_one_hot) begin
          expected_d = q_rot;
          pos_d      = q_index;
          state_d    = TRACK;
        end
      end
      default: state_d = UNSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNSYNC;
      expected_q <= '0;
      pos_q      <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      pos_q      <= pos_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.locked     = (state_q == TRACK);
  assign bus.pos        = pos_q;
  assign bus.wrap       = wrap_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_count  = cnt_q;
endmodule

// File: tb/tb_ring_sequence_checker.sv
// Scoreboard bench for ring_sequence_checker: directed samples push expected
// status into a queue, a monitor compares after every clock edge.
module tb_ring_sequence_checker;
  localparam int WIDTH     = 4;
  localparam int ERR_CNT_W = 2;
  localparam int POS_W     = $clog2(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b1;

  ring_seq_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  ring_sequence_checker #(.WIDTH(WIDTH), .POS_W(POS_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;   // {locked, pos[1:0], wrap, err, sticky, count[1:0]} plus spare msb
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = sb.pop_front();
      act = {1'b0, bus.locked, bus.pos, bus.wrap, bus.err, bus.err_sticky, bus.err_count};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s: got lk=%b pos=%0d wr=%b er=%b st=%b cnt=%0d want lk=%b pos=%0d wr=%b er=%b st=%b cnt=%0d",
                 e.name, act[7], act[6:5], act[4], act[3], act[2], act[1:0],
                 e.v[7], e.v[6:5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
      end
    end
  end

  task automatic step(input logic r, input logic rs, input logic [3:0] q,
                      input logic lk, input int p, input logic wr, input logic er,
                      input logic st, input int cnt, input string name);
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.resync = rs;
    bus.q_in   = q;
    e.v    = {1'b0, lk, 2'(p), wr, er, st, 2'(cnt)};
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    bus.resync = 1'b0;
    bus.q_in   = '0;

    // 1: clean rotation and wrap
    step(1, 0, 4'b0001, 0, 0, 0, 0, 0, 0, "t1_reset");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t1_s0");
    step(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "t1_s1");
    step(0, 0, 4'b0100, 1, 2, 0, 0, 0, 0, "t1_s2");
    step(0, 0, 4'b1000, 1, 3, 0, 0, 0, 0, "t1_s3");
    step(0, 0, 4'b0001, 1, 0, 1, 0, 0, 0, "t1_wrap");
    step(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "t1_after_wrap");

    // 2: mismatch, recovery, then a normal wrap
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t2_reset");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t2_lock");
    step(0, 0, 4'b0100, 0, 0, 0, 1, 1, 1, "t2_mismatch");
    step(0, 0, 4'b1000, 1, 3, 0, 0, 1, 1, "t2_relock");
    step(0, 0, 4'b0001, 1, 0, 1, 0, 1, 1, "t2_wrap");

    // 3: resync jumps are not errors and do not wrap
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t3_reset");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t3_lock");
    step(0, 1, 4'b0100, 1, 2, 0, 0, 0, 0, "t3_resync_jump");
    step(0, 0, 4'b1000, 1, 3, 0, 0, 0, 0, "t3_follow");
    step(0, 1, 4'b1000, 1, 3, 0, 0, 0, 0, "t3_resync_same");
    step(0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, "t3_resync_no_wrap");
    step(0, 0, 4'b0010, 1, 1, 0, 0, 0, 0, "t3_follow2");

    // 4: invalid patterns in each state
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t4_reset");
    step(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t4_unsync_zero");
    step(0, 0, 4'b0110, 0, 0, 0, 0, 0, 0, "t4_unsync_multi");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t4_lock");
    step(0, 0, 4'b0110, 0, 0, 0, 1, 1, 1, "t4_track_multi_err");
    step(0, 0, 4'b0000, 0, 0, 0, 0, 1, 1, "t4_err_hold");
    step(0, 0, 4'b0010, 1, 1, 0, 0, 1, 1, "t4_err_relock");
    step(0, 1, 4'b0110, 0, 1, 0, 0, 1, 1, "t4_resync_invalid");
    step(0, 0, 4'b0100, 1, 2, 0, 0, 1, 1, "t4_unsync_relock");

    // 5: saturating error count
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t5_reset");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t5_lock");
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 4'b0001, 0, 0, 0, 1, 1, (i > 3) ? 3 : i, $sformatf("t5_err%0d", i));
      step(0, 0, 4'b0001, 1, 0, 0, 0, 1, (i > 3) ? 3 : i, $sformatf("t5_relock%0d", i));
    end

    // 6: reset mid-operation
    step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, "t6_reset");
    step(0, 0, 4'b0001, 1, 0, 0, 0, 0, 0, "t6_lock");
    step(0, 0, 4'b0100, 0, 0, 0, 1, 1, 1, "t6_err1");
    step(0, 0, 4'b1000, 1, 3, 0, 0, 1, 1, "t6_relock1");
    step(0, 0, 4'b0010, 0, 3, 0, 1, 1, 2, "t6_err2");
    step(0, 0, 4'b0100, 1, 2, 0, 0, 1, 2, "t6_relock2");
    step(1, 1, 4'b1000, 0, 0, 0, 0, 0, 0, "t6_mid_reset");
    step(0, 0, 4'b0100, 1, 2, 0, 0, 0, 0, "t6_after_reset");

    begin
      int budget;
      budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
